// File: rtl/secuenciador_mc.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback FSM
// with request-timeout trapping, illegal-opcode trapping and a retired counter.
module secuenciador_mc #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic [1:0]  pc_sel,
   output logic [1:0]  wb_sel,
   output logic [4:0]  rf_waddr,
   output logic [5:0]  alu_op,
   output logic        halted,
   output logic [1:0]  trap_cause,
   output logic [15:0] retired
);

   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [WW-1:0]  r_wait;
   logic [1:0]     r_trap;
   logic [15:0]    r_retired;

   logic           w_setTrap;
   logic [1:0]     w_trapVal;
   logic           w_retire;
   logic [1:0]     w_op;
   logic [4:0]     w_rd;
   logic [5:0]     w_op3;
   logic           w_isAlu;
   logic           w_isLd;
   logic           w_isSt;
   logic           w_isCall;
   logic           w_unusedIr;

   assign w_op       = ir[31:30];
   assign w_rd       = ir[29:25];
   assign w_op3      = ir[24:19];
   assign w_unusedIr = ^ir[18:0];

   assign w_isAlu  = (w_op == 2'd2) && (w_op3[5:3] == 3'b000);
   assign w_isLd   = (w_op == 2'd3) && (w_op3 == 6'b000000);
   assign w_isSt   = (w_op == 2'd3) && (w_op3 == 6'b000100);
   assign w_isCall = (w_op == 2'd1);

   // Next-state and strobe decode; every strobe defaults low so HALT and IDLE are quiet.
   always_comb begin
      w_next    = r_state;
      w_setTrap = 1'b0;
      w_trapVal = 2'b00;
      w_retire  = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_sel    = 2'd0;
      wb_sel    = 2'd0;
      rf_waddr  = 5'd0;
      alu_op    = 6'd0;
      case (r_state)
         IDLE: w_next = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we  = 1'b1;
               w_next = DECODE;
            end else if (r_wait == WAIT_LAST) begin
               w_next    = HALT;
               w_setTrap = 1'b1;
               w_trapVal = 2'b10;
            end
         end
         DECODE: begin
            if (w_isAlu || w_isLd || w_isSt) begin
               w_next = EXEC;
            end else if (w_isCall) begin
               w_next = WB;
            end else begin
               w_next    = HALT;
               w_setTrap = 1'b1;
               w_trapVal = 2'b01;
            end
         end
         EXEC: begin
            alu_op = w_isAlu ? w_op3 : 6'd0;
            w_next = w_isAlu ? WB : MEM;
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = w_isSt;
            if (dmem_ack) begin
               if (w_isSt) begin
                  pc_we    = 1'b1;
                  w_retire = 1'b1;
                  w_next   = FETCH;
               end else begin
                  w_next = WB;
               end
            end else if (r_wait == WAIT_LAST) begin
               w_next    = HALT;
               w_setTrap = 1'b1;
               w_trapVal = 2'b10;
            end
         end
         WB: begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
            w_next   = FETCH;
            if (w_isCall) begin
               rf_waddr = 5'd15;
               wb_sel   = 2'd2;
               pc_sel   = 2'd1;
            end else begin
               rf_waddr = w_rd;
               wb_sel   = w_isLd ? 2'd1 : 2'd0;
            end
            rf_we = (rf_waddr != 5'd0);
         end
         HALT: w_next = HALT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The wait counter restarts whenever a fresh request phase begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait <= '0;
      end else if ((w_next != r_state) && ((w_next == FETCH) || (w_next == MEM))) begin
         r_wait <= '0;
      end else if (((r_state == FETCH) && !imem_ack) || ((r_state == MEM) && !dmem_ack)) begin
         r_wait <= r_wait + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_trap    <= 2'b00;
         r_retired <= 16'd0;
      end else begin
         if (w_setTrap) begin
            r_trap <= w_trapVal;
         end
         if (w_retire) begin
            r_retired <= r_retired + 16'd1;
         end
      end
   end

   assign halted     = (r_state == HALT);
   assign trap_cause = r_trap;
   assign retired    = r_retired;

endmodule

// File: tb/tb_secuenciador_mc.sv
// Directed bench for secuenciador_mc: stimulus pushes the expected output word
// for every cycle into a queue, and a negedge monitor pops and compares it.
module tb_secuenciador_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ir = 32'd0;
   logic        imemAck = 1'b0;
   logic        dmemAck = 1'b0;
   logic        imemReq, dmemReq, dmemWe, irWe, pcWe, rfWe, halted;
   logic [1:0]  pcSel, wbSel, trapCause;
   logic [4:0]  rfWaddr;
   logic [5:0]  aluOp;
   logic [15:0] retired;

   typedef struct {
      string       name;
      logic [39:0] value;
   } expT;

   expT         expQ[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] expRet = 16'd0;
   logic        finished = 1'b0;

   always #5 clk = ~clk;

   secuenciador_mc #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .ir        (ir),
      .imem_ack  (imemAck),
      .dmem_ack  (dmemAck),
      .imem_req  (imemReq),
      .dmem_req  (dmemReq),
      .dmem_we   (dmemWe),
      .ir_we     (irWe),
      .pc_we     (pcWe),
      .rf_we     (rfWe),
      .pc_sel    (pcSel),
      .wb_sel    (wbSel),
      .rf_waddr  (rfWaddr),
      .alu_op    (aluOp),
      .halted    (halted),
      .trap_cause(trapCause),
      .retired   (retired)
   );

   // Packs one cycle of outputs; field order matches the monitor snapshot.
   function automatic logic [39:0] mk(
      input logic iReq, input logic dReq, input logic dWe, input logic iWe,
      input logic pWe, input logic rWe, input logic [1:0] pSel, input logic [1:0] wSel,
      input logic [4:0] wa, input logic [5:0] alu, input logic hlt,
      input logic [1:0] trap, input logic [15:0] ret);
      return {iReq, dReq, dWe, iWe, pWe, rWe, pSel, wSel, wa, alu, hlt, trap, ret};
   endfunction

   task automatic applyStimulus(input logic r, input logic ia, input logic da,
                                input logic [39:0] want, input string nm);
      expT e;
      rst     = r;
      imemAck = ia;
      dmemAck = da;
      e.name  = nm;
      e.value = want;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic rstCyc(input string nm);
      expRet = 16'd0;
      applyStimulus(1'b1, 1'b1, 1'b1,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 6'd0, 1'b0, 2'b00, 16'd0), nm);
   endtask

   task automatic quietCyc(input logic [5:0] alu, input string nm);
      applyStimulus(1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, alu, 1'b0, 2'b00, expRet), nm);
   endtask

   task automatic fetchCyc(input logic ack, input string nm);
      applyStimulus(1'b0, ack, 1'b0,
         mk(1'b1, 1'b0, 1'b0, ack, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 6'd0, 1'b0, 2'b00, expRet), nm);
   endtask

   task automatic memCyc(input logic we, input logic ack, input string nm);
      applyStimulus(1'b0, 1'b0, ack,
         mk(1'b0, 1'b1, we, 1'b0, we & ack, 1'b0, 2'd0, 2'd0, 5'd0, 6'd0, 1'b0, 2'b00, expRet), nm);
      if (we && ack) expRet = expRet + 16'd1;
   endtask

   task automatic wbCyc(input logic rWe, input logic [4:0] wa, input logic [1:0] wSel,
                        input logic [1:0] pSel, input string nm);
      applyStimulus(1'b0, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rWe, pSel, wSel, wa, 6'd0, 1'b0, 2'b00, expRet), nm);
      expRet = expRet + 16'd1;
   endtask

   task automatic haltCyc(input logic [1:0] trap, input string nm);
      applyStimulus(1'b0, 1'b1, 1'b1,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 6'd0, 1'b1, trap, expRet), nm);
   endtask

   task automatic checkOutput(input string nm, input logic [39:0] got, input logic [39:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h want %h at t=%0t", nm, got, want, $time);
      end
   endtask

   // Monitor: one expectation per cycle while the queue holds entries; strobes with nothing queued are errors.
   always @(negedge clk) begin
      logic [39:0] got;
      expT         e;
      got = {imemReq, dmemReq, dmemWe, irWe, pcWe, rfWe, pcSel, wbSel,
             rfWaddr, aluOp, halted, trapCause, retired};
      if (finished) begin
         checkOutput("queueDrain", 40'(expQ.size()), 40'd0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end else if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput(e.name, got, e.value);
      end else if (imemReq || dmemReq || irWe || pcWe || rfWe) begin
         checkOutput("strobeWithoutExpectation",
                     {34'd0, imemReq, dmemReq, dmemWe, irWe, pcWe, rfWe}, 40'd0);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset and ADD");
      ir = 32'h8A004002;
      rstCyc("rstHold0");
      rstCyc("rstHold1");
      quietCyc(6'd0, "idleAfterRst");
      fetchCyc(1'b1, "addFetch");
      quietCyc(6'd0, "addDecode");
      quietCyc(6'd0, "addExec");
      wbCyc(1'b1, 5'd5, 2'd0, 2'd0, "addWb");

      $display("[TB] ALU op3=3 rd=0 with fetch wait");
      ir = 32'h80180000;
      fetchCyc(1'b0, "aluFetchWait0");
      fetchCyc(1'b0, "aluFetchWait1");
      fetchCyc(1'b1, "aluFetchAck");
      quietCyc(6'd0, "aluDecode");
      quietCyc(6'd3, "aluExec");
      wbCyc(1'b0, 5'd0, 2'd0, 2'd0, "aluWbRd0");

      $display("[TB] LD rd=7 with 3-cycle dmem delay");
      ir = 32'hCE000000;
      fetchCyc(1'b1, "ldFetch");
      quietCyc(6'd0, "ldDecode");
      quietCyc(6'd0, "ldExec");
      memCyc(1'b0, 1'b0, "ldMem0");
      memCyc(1'b0, 1'b0, "ldMem1");
      memCyc(1'b0, 1'b0, "ldMem2");
      memCyc(1'b0, 1'b1, "ldMemAck");
      wbCyc(1'b1, 5'd7, 2'd1, 2'd0, "ldWb");

      $display("[TB] ST");
      ir = 32'hD2200000;
      fetchCyc(1'b1, "stFetch");
      quietCyc(6'd0, "stDecode");
      quietCyc(6'd0, "stExec");
      memCyc(1'b1, 1'b0, "stMemWait");
      memCyc(1'b1, 1'b1, "stMemAck");

      $display("[TB] CALL");
      ir = 32'h40000123;
      fetchCyc(1'b1, "callFetch");
      quietCyc(6'd0, "callDecode");
      wbCyc(1'b1, 5'd15, 2'd2, 2'd1, "callWb");

      $display("[TB] retired wrap");
      force dut.r_retired = 16'hFFFE;
      #1;
      release dut.r_retired;
      expRet = 16'hFFFE;
      fetchCyc(1'b1, "wrapFetch0");
      quietCyc(6'd0, "wrapDecode0");
      wbCyc(1'b1, 5'd15, 2'd2, 2'd1, "wrapWb0");
      fetchCyc(1'b1, "wrapFetch1");
      quietCyc(6'd0, "wrapDecode1");
      wbCyc(1'b1, 5'd15, 2'd2, 2'd1, "wrapWb1");

      $display("[TB] reset mid-MEM");
      ir = 32'hCE000000;
      fetchCyc(1'b1, "midFetch");
      quietCyc(6'd0, "midDecode");
      quietCyc(6'd0, "midExec");
      memCyc(1'b0, 1'b0, "midMem");
      rstCyc("rstMidMem");
      rstCyc("rstMidMemHold");

      $display("[TB] illegal op3");
      ir = 32'h80400000;
      quietCyc(6'd0, "idleAfterMidRst");
      fetchCyc(1'b1, "illFetch");
      quietCyc(6'd0, "illDecode");
      for (int i = 0; i < 21; i++) haltCyc(2'b01, "illHalt");
      rstCyc("rstAfterHalt");

      $display("[TB] fetch timeout");
      quietCyc(6'd0, "idleBeforeTimeout");
      for (int i = 0; i < 16; i++) fetchCyc(1'b0, "toFetch");
      for (int i = 0; i < 4; i++) haltCyc(2'b10, "toHalt");

      finished = 1'b1;
   end

endmodule
